// File: rtl/if_fetch_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_pkg
// Shared definitions for the instruction-fetch stage: default bus widths,
// the boot PC, the bubble instruction, the sequential PC step and the
// fetch FSM state encoding.
// ---------------------------------------------------------------------------
package if_fetch_pkg;

    // Default PC / ROM address width and instruction width.
    localparam int ADDR_BUS = 32;
    localparam int INST_BUS = 32;

    // First fetch address after reset (MIPS boot vector).
    localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;

    // Value presented on inst_o whenever no valid instruction is held.
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

    // Byte distance between consecutive instructions.
    localparam int unsigned PC_INC = 32'd4;

    // Fetch FSM states.
    //   ST_FETCH : may issue a request for the current PC
    //   ST_WAIT  : one request outstanding, its data will be presented
    //   ST_DROP  : one request outstanding, its data will be discarded
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DROP  = 2'd2
    } fetch_state_e;

endpackage : if_fetch_pkg

// File: rtl/if_fetch_if.sv
// ---------------------------------------------------------------------------
// if_fetch_if
// Instruction ROM request/response port.
//   rom_req    : fetch request valid            (fetch -> ROM)
//   rom_addr   : fetch address                  (fetch -> ROM)
//   rom_ready  : ROM accepts the request        (ROM -> fetch)
//   rom_rvalid : read data valid, >=1 cycle after accept (ROM -> fetch)
//   rom_rdata  : read data                      (ROM -> fetch)
// The fetch stage uses the master modport, the ROM the slave modport.
// ---------------------------------------------------------------------------
interface if_fetch_if
    import if_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_BUS,
    parameter int INST_WIDTH = INST_BUS
);

    logic                  rom_req;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic                  rom_ready;
    logic                  rom_rvalid;
    logic [INST_WIDTH-1:0] rom_rdata;

    modport master (
        output rom_req,
        output rom_addr,
        input  rom_ready,
        input  rom_rvalid,
        input  rom_rdata
    );

    modport slave (
        input  rom_req,
        input  rom_addr,
        output rom_ready,
        output rom_rvalid,
        output rom_rdata
    );

endinterface : if_fetch_if

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
// Instruction-fetch stage sitting directly upstream of the IF/ID register.
// Owns the PC, keeps at most one ROM request outstanding, and redirects on
// ID-stage branches (MIPS delay slot preserved) and on exception flushes.
//
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   stall_current_stage  : IF held; the presented instruction is not consumed
//   branch_flag/addr     : taken branch/jump resolved in ID this cycle
//   flush/flush_pc       : exception/eret redirect, wins over branch_flag
//   rom                  : instruction ROM port (master side)
//   addr_o / inst_o      : PC and instruction presented to IF/ID
//   stall_request        : high while no valid instruction is presented
// ---------------------------------------------------------------------------
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = ADDR_BUS,
    parameter int                    INST_WIDTH = INST_BUS,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEF),
    parameter logic [INST_WIDTH-1:0] NOP_INST   = INST_WIDTH'(NOP_INST_DEF)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_current_stage,
    input  logic                  branch_flag,
    input  logic [ADDR_WIDTH-1:0] branch_addr,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] flush_pc,
    if_fetch_if.master            rom,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [INST_WIDTH-1:0] inst_o,
    output logic                  stall_request
);

    fetch_state_e          state_r;
    logic [ADDR_WIDTH-1:0] pc_r;
    logic [ADDR_WIDTH-1:0] out_addr_r;
    logic [INST_WIDTH-1:0] out_inst_r;
    logic                  out_valid_r;
    logic                  redir_pending_r;
    logic [ADDR_WIDTH-1:0] redir_addr_r;

    logic                  rom_req_s;
    logic                  accept_s;
    logic                  outstanding_s;
    logic [ADDR_WIDTH-1:0] pc_inc_s;

    // Request gating: never fetch while a held instruction is stalled, so a
    // response can never land on top of a live unconsumed instruction.
    always_comb begin
        rom_req_s = 1'b0;
        if (!rst && (state_r == ST_FETCH)) begin
            rom_req_s = !(out_valid_r && stall_current_stage);
        end else begin
            rom_req_s = 1'b0;
        end
    end

    assign rom.rom_req  = rom_req_s;
    assign rom.rom_addr = pc_r;

    assign accept_s = rom_req_s && rom.rom_ready;

    // A request is still in flight after this edge if one is accepted now,
    // or one was pending and its data does not arrive this cycle.
    assign outstanding_s = accept_s ||
                           (((state_r == ST_WAIT) || (state_r == ST_DROP)) && !rom.rom_rvalid);

    // Sequential next PC; wraps modulo 2^ADDR_WIDTH.
    assign pc_inc_s = pc_r + ADDR_WIDTH'(PC_INC);

    // Presentation to IF/ID, combinational from registers only.
    assign addr_o        = out_addr_r;
    assign inst_o        = out_valid_r ? out_inst_r : NOP_INST;
    assign stall_request = !out_valid_r;

    // Fetch FSM together with PC, output holding register and redirect latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= ST_FETCH;
            pc_r            <= RESET_PC;
            out_addr_r      <= RESET_PC;
            out_inst_r      <= NOP_INST;
            out_valid_r     <= 1'b0;
            redir_pending_r <= 1'b0;
            redir_addr_r    <= RESET_PC;
        end else begin
            // Consumption; a refill later in this block overrides it.
            if (out_valid_r && !stall_current_stage) begin
                out_valid_r <= 1'b0;
            end

            if (flush) begin
                out_valid_r     <= 1'b0;
                redir_pending_r <= 1'b0;
                pc_r            <= flush_pc;
                state_r         <= outstanding_s ? ST_DROP : ST_FETCH;
            end else begin
                case (state_r)
                    ST_FETCH: begin
                        if (accept_s) begin
                            // With a branch, the delay slot is already held, so
                            // the request just accepted lies beyond it.
                            if (branch_flag) begin
                                pc_r    <= branch_addr;
                                state_r <= ST_DROP;
                            end else begin
                                state_r <= ST_WAIT;
                            end
                        end else if (branch_flag) begin
                            pc_r <= branch_addr;
                        end
                    end

                    ST_WAIT: begin
                        if (rom.rom_rvalid) begin
                            out_addr_r      <= pc_r;
                            out_inst_r      <= rom.rom_rdata;
                            out_valid_r     <= 1'b1;
                            redir_pending_r <= 1'b0;
                            state_r         <= ST_FETCH;
                            if (branch_flag) begin
                                pc_r <= branch_addr;
                            end else if (redir_pending_r) begin
                                pc_r <= redir_addr_r;
                            end else begin
                                pc_r <= pc_inc_s;
                            end
                        end else if (branch_flag) begin
                            // In-flight instruction is the delay slot; redirect
                            // once it has been captured.
                            redir_pending_r <= 1'b1;
                            redir_addr_r    <= branch_addr;
                        end
                    end

                    ST_DROP: begin
                        if (branch_flag) begin
                            pc_r <= branch_addr;
                        end
                        if (rom.rom_rvalid) begin
                            state_r <= ST_FETCH;
                        end
                    end

                    default: begin
                        state_r <= ST_FETCH;
                    end
                endcase
            end
        end
    end

endmodule : if_fetch

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] MAGIC  = 32'h1111_1111;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_flag;
    logic [31:0] branch_addr;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] addr_o;
    logic [31:0] inst_o;
    logic        stall_request;

    if_fetch_if bus ();

    if_fetch dut (
        .clk                 (clk),
        .rst                 (rst),
        .stall_current_stage (stall),
        .branch_flag         (branch_flag),
        .branch_addr         (branch_addr),
        .flush               (flush),
        .flush_pc            (flush_pc),
        .rom                 (bus.master),
        .addr_o              (addr_o),
        .inst_o              (inst_o),
        .stall_request       (stall_request)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ROM behavioural model: one request at a time, data = addr ^ MAGIC.
    bit          rom_pend;
    logic [31:0] rom_paddr;
    int          rom_cnt;
    int          ready_pct;
    int          lat_min;
    int          lat_max;

    // Program-order reference: the stream of consumed instructions.
    bit          model_on;
    logic [31:0] exp_addr;
    bit          br_armed;
    logic [31:0] br_delay;
    logic [31:0] br_target;
    int          n_cons;
    int          idle;

    // Values sampled just before each active edge.
    logic        s_req, s_rdy, s_rv, s_pres, s_stall;
    logic [31:0] s_addr, s_aout, s_iout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
        end
    endtask

    task automatic drive_rom();
        bus.rom_rvalid = rom_pend && (rom_cnt == 0);
        bus.rom_rdata  = bus.rom_rvalid ? (rom_paddr ^ MAGIC) : $urandom();
        bus.rom_ready  = !rom_pend && ($urandom_range(99) < ready_pct);
    endtask

    // Sample, score consumption, cross one clock edge, advance the ROM model.
    task automatic next();
        s_req   = bus.rom_req;
        s_addr  = bus.rom_addr;
        s_rdy   = bus.rom_ready;
        s_rv    = bus.rom_rvalid;
        s_pres  = !stall_request;
        s_aout  = addr_o;
        s_iout  = inst_o;
        s_stall = stall;
        if (s_pres && s_stall) chk("req_gate", 32'(s_req), 32'd0);
        if (model_on) begin
            idle++;
            if (s_pres && !s_stall) begin
                chk("stream_addr", s_aout, exp_addr);
                chk("stream_inst", s_iout, exp_addr ^ MAGIC);
                n_cons++;
                idle = 0;
                if (br_armed && (exp_addr == br_delay)) begin
                    exp_addr = br_target;
                    br_armed = 1'b0;
                end else begin
                    exp_addr = exp_addr + 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
        if (s_rv) rom_pend = 1'b0;
        else if (rom_pend && (rom_cnt > 0)) rom_cnt--;
        if (s_req && s_rdy) begin
            rom_pend  = 1'b1;
            rom_paddr = s_addr;
            rom_cnt   = int'($urandom_range(lat_max, lat_min)) - 1;
        end
        drive_rom();
    endtask

    task automatic wait_present(input string tag, input logic [31:0] ea);
        int k = 0;
        #1;
        while (stall_request && (k < 40)) begin
            next();
            #1;
            k++;
        end
        chk({tag, "_valid"}, 32'(stall_request), 32'd0);
        chk({tag, "_addr"}, addr_o, ea);
        chk({tag, "_inst"}, inst_o, ea ^ MAGIC);
    endtask

    initial begin
        logic [31:0] t;
        rst = 1'b1; stall = 1'b0; branch_flag = 1'b0; branch_addr = 32'd0;
        flush = 1'b0; flush_pc = 32'd0;
        rom_pend = 1'b0; rom_paddr = 32'd0; rom_cnt = 0;
        ready_pct = 100; lat_min = 1; lat_max = 1;
        model_on = 1'b0; exp_addr = RST_PC; br_armed = 1'b0;
        br_delay = 32'd0; br_target = 32'd0; n_cons = 0; idle = 0;
        drive_rom();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_req", 32'(bus.rom_req), 32'd0);
        chk("rst_addr", addr_o, RST_PC);
        chk("rst_inst", inst_o, NOP);
        chk("rst_stall", 32'(stall_request), 32'd1);
        rst = 1'b0;
        #1;
        // Sequential fetch with a 1-cycle ROM.
        chk("c0_req", 32'(bus.rom_req), 32'd1);
        chk("c0_raddr", bus.rom_addr, RST_PC);
        chk("c0_stall", 32'(stall_request), 32'd1);
        next();
        #1; chk("c1_req", 32'(bus.rom_req), 32'd0); chk("c1_stall", 32'(stall_request), 32'd1); next();
        #1; chk("c2_stall", 32'(stall_request), 32'd0); chk("c2_addr", addr_o, 32'hBFC0_0000);
            chk("c2_inst", inst_o, 32'hBFC0_0000 ^ MAGIC); chk("c2_raddr", bus.rom_addr, 32'hBFC0_0004); next();
        #1; chk("c3_stall", 32'(stall_request), 32'd1); next();
        #1; chk("c4_inst", inst_o, 32'hBFC0_0004 ^ MAGIC); chk("c4_raddr", bus.rom_addr, 32'hBFC0_0008); next();
        #1; chk("c5_stall", 32'(stall_request), 32'd1); next();
        // Hold IF for 5 cycles with an instruction presented.
        stall = 1'b1;
        #1; chk("c6_inst", inst_o, 32'hBFC0_0008 ^ MAGIC); next();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("hold_req", 32'(bus.rom_req), 32'd0);
            chk("hold_addr", addr_o, 32'hBFC0_0008);
            chk("hold_inst", inst_o, 32'hBFC0_0008 ^ MAGIC);
            next();
        end
        stall = 1'b0;
        #1; chk("rel_inst", inst_o, 32'hBFC0_0008 ^ MAGIC); chk("rel_req", 32'(bus.rom_req), 32'd1);
            chk("rel_raddr", bus.rom_addr, 32'hBFC0_000C); next();
        // Branch while the delay slot is in flight.
        branch_flag = 1'b1; branch_addr = 32'h8000_0100;
        #1; chk("br_wait_stall", 32'(stall_request), 32'd1); next();
        branch_flag = 1'b0;
        #1; chk("ds_inst", inst_o, 32'hBFC0_000C ^ MAGIC); chk("ds_raddr", bus.rom_addr, 32'h8000_0100); next();
        #1; next();
        #1; chk("tgt_inst", inst_o, 32'h8000_0100 ^ MAGIC); chk("tgt_raddr", bus.rom_addr, 32'h8000_0104); next();
        #1; next();
        // Branch in the accept cycle of the instruction after the presented delay slot.
        branch_flag = 1'b1; branch_addr = 32'h8000_0200;
        #1; chk("ds2_inst", inst_o, 32'h8000_0104 ^ MAGIC); chk("ds2_raddr", bus.rom_addr, 32'h8000_0108);
            chk("ds2_req", 32'(bus.rom_req), 32'd1); next();
        branch_flag = 1'b0;
        #1; chk("drop_stall", 32'(stall_request), 32'd1); next();
        #1; chk("drop_done", 32'(stall_request), 32'd1); chk("drop_raddr", bus.rom_addr, 32'h8000_0200);
            chk("drop_req", 32'(bus.rom_req), 32'd1); next();
        #1; next();
        lat_min = 3; lat_max = 3;
        #1; chk("tgt2_inst", inst_o, 32'h8000_0200 ^ MAGIC); next();
        // Flush together with a branch while a request is outstanding.
        flush = 1'b1; flush_pc = 32'hBFC0_0380; branch_flag = 1'b1; branch_addr = 32'h8000_0300;
        #1; next();
        flush = 1'b0; branch_flag = 1'b0;
        #1; chk("fl_inst", inst_o, NOP); chk("fl_stall", 32'(stall_request), 32'd1);
            chk("fl_req", 32'(bus.rom_req), 32'd0); next();
        #1; chk("fl_req2", 32'(bus.rom_req), 32'd0); next();
        #1; chk("fl_raddr", bus.rom_addr, 32'hBFC0_0380); chk("fl_req3", 32'(bus.rom_req), 32'd1); next();
        wait_present("flush_tgt", 32'hBFC0_0380);
        next();
        // Reset during WAIT; its response arrives after reset is released.
        rst = 1'b1;
        #1; chk("mr_req", 32'(bus.rom_req), 32'd0); chk("mr_addr", addr_o, RST_PC);
            chk("mr_inst", inst_o, NOP); chk("mr_stall", 32'(stall_request), 32'd1); next();
        rst = 1'b0;
        wait_present("post_rst", RST_PC);
        next();
        // PC wrap at the top of the address space.
        flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
        #1; next();
        flush = 1'b0;
        wait_present("wrap0", 32'hFFFF_FFFC);
        next();
        wait_present("wrap1", 32'h0000_0000);

        // Randomised run against the program-order reference.
        rst = 1'b1;
        #1; next();
        rst = 1'b0;
        model_on = 1'b1; exp_addr = RST_PC; br_armed = 1'b0;
        ready_pct = 70; lat_min = 1; lat_max = 3; idle = 0; n_cons = 0;
        for (int i = 0; (i < 1500) && (idle < 60); i++) begin
            stall = ($urandom_range(99) < 30);
            branch_flag = 1'b0;
            if (!br_armed && ($urandom_range(99) < 25) &&
                ((!stall_request && (addr_o == exp_addr)) ||
                 (stall_request && rom_pend && (rom_paddr == exp_addr)))) begin
                br_delay = exp_addr;
                t = 32'h8000_0000 | (32'($urandom_range(1023)) << 2);
                while (t == br_delay + 32'd8) t = t + 32'd16;
                br_target = t;
                branch_addr = t;
                branch_flag = 1'b1;
                br_armed = 1'b1;
            end
            #1;
            next();
        end
        branch_flag = 1'b0;
        chk("rand_progress", 32'(idle < 60), 32'd1);
        chk("rand_count", 32'(n_cons > 100), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_if_fetch
